// File: rtl/receptor_comando_servos.sv
// receptor_comando_servos: parses "#ddd." frames into three atomically updated 2-bit servo positions.
// Define RECEPTOR_ECO_EN to emit a K/E acknowledge character for each accepted or aborted frame.
module receptor_comando_servos #(
  parameter int TIMEOUT_CICLOS = 1_000_000,
  parameter int TIMEOUT_BITS   = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] dado_ascii,
  input  logic       pronto_rx,
  output logic [1:0] posicao1,
  output logic [1:0] posicao2,
  output logic [1:0] posicao3,
  output logic       atualizado,
  output logic       erro,
  output logic [6:0] eco_dado,
  output logic       eco_partida,
  output logic [3:0] db_estado
);
  typedef enum logic [3:0] {
    ESPERA_INICIO = 4'd0,
    RECEBE_1      = 4'd1,
    RECEBE_2      = 4'd2,
    RECEBE_3      = 4'd3,
    ESPERA_FIM    = 4'd4,
    ATUALIZA      = 4'd5,
    ERRO          = 4'd6
  } estado_t;
  // The abort fires on the edge where the idle count would reach TIMEOUT_CICLOS-1.
  localparam logic [TIMEOUT_BITS-1:0] LIMITE = TIMEOUT_BITS'(TIMEOUT_CICLOS - 2);
  estado_t                 estado_q;
  logic [2:0][1:0]         sombra_q;
  logic [TIMEOUT_BITS-1:0] cnt_q;
  logic                    ativo, inicio, avanca, fim_ok, falha;
  always_comb begin
    ativo  = estado_q inside {RECEBE_1, RECEBE_2, RECEBE_3, ESPERA_FIM};
    inicio = pronto_rx && dado_ascii == 7'h23 && (ativo || estado_q == ESPERA_INICIO);
    avanca = ativo && pronto_rx && estado_q != ESPERA_FIM && dado_ascii[6:2] == 5'b01100;
    fim_ok = ativo && pronto_rx && estado_q == ESPERA_FIM && dado_ascii == 7'h2E;
    falha  = ativo && (pronto_rx ? !(inicio || avanca || fim_ok) : cnt_q == LIMITE);
  end
  // sombra_q[2] holds servo 1 so the concatenation maps straight onto the outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= ESPERA_INICIO;
      sombra_q   <= '0;
      cnt_q      <= '0;
      posicao1   <= 2'b00;
      posicao2   <= 2'b00;
      posicao3   <= 2'b00;
      atualizado <= 1'b0;
      erro       <= 1'b0;
    end else begin
      atualizado <= fim_ok;
      erro       <= falha;
      cnt_q      <= (ativo && !pronto_rx) ? cnt_q + 1'b1 : '0;
      if (fim_ok) {posicao1, posicao2, posicao3} <= sombra_q;
      if (avanca) sombra_q[2'(4'd3 - estado_q)] <= dado_ascii[1:0];
      else if (inicio) sombra_q <= '0;
      estado_q <= inicio ? RECEBE_1 : fim_ok ? ATUALIZA : falha ? ERRO :
                  avanca ? estado_t'(estado_q + 4'd1) : ativo ? estado_q : ESPERA_INICIO;
    end
  end
  assign db_estado = estado_q;
`ifdef RECEPTOR_ECO_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      eco_dado    <= 7'h00;
      eco_partida <= 1'b0;
    end else begin
      eco_partida <= fim_ok || falha;
      if (fim_ok || falha) eco_dado <= fim_ok ? 7'h4B : 7'h45;
    end
  end
`else
  assign eco_dado    = 7'h00;
  assign eco_partida = 1'b0;
`endif
endmodule

// File: tb/tb_receptor_comando_servos.sv
// tb_receptor_comando_servos: frame-level reference model checked every cycle, plus table and corner sequences.
module tb_receptor_comando_servos;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] dado_ascii = '0;
  logic       pronto_rx = 1'b0;
  logic [1:0] posicao1, posicao2, posicao3;
  logic       atualizado, erro, eco_partida;
  logic [6:0] eco_dado;
  logic [3:0] db_estado;

  receptor_comando_servos #(.TIMEOUT_CICLOS(50), .TIMEOUT_BITS(20)) dut (
    .clock(clock), .reset(reset), .dado_ascii(dado_ascii), .pronto_rx(pronto_rx),
    .posicao1(posicao1), .posicao2(posicao2), .posicao3(posicao3),
    .atualizado(atualizado), .erro(erro), .eco_dado(eco_dado),
    .eco_partida(eco_partida), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0, cyc = 0, last = 0, na = 0, ne = 0;
  byte fr[$];
  logic [6:0] ecos[$];
  logic [5:0] exp_pos = '0;
  logic exp_at = 0, exp_er = 0, exp_eco_p = 0;
  logic [3:0] exp_db = '0;
  logic [6:0] exp_eco_d = '0;

  function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    pronto_rx = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    cyc++;
    fr.delete();
    exp_pos = '0; exp_at = 0; exp_er = 0; exp_db = '0; exp_eco_d = '0; exp_eco_p = 0;
  endtask

  // One clock: check this cycle's outputs, then advance the frame model with this cycle's inputs.
  task automatic step(input logic p, input logic [6:0] c);
    logic n_at, n_er;
    pronto_rx = p;
    dado_ascii = c;
    chk("posicoes", {posicao1, posicao2, posicao3}, exp_pos);
    chk("pulsos", {atualizado, erro}, {exp_at, exp_er});
    chk("db_estado", db_estado, exp_db);
    chk("eco", {eco_dado, eco_partida}, {exp_eco_d, exp_eco_p});
    na += int'(atualizado);
    ne += int'(erro);
    if (eco_partida) ecos.push_back(eco_dado);
    n_at = 0;
    n_er = 0;
    if (p) begin
      last = cyc;
      if (c == 7'h23) begin
        fr.delete();
        fr.push_back(8'h23);
      end else if (fr.size() == 0) begin
      end else if (fr.size() < 4 && c >= 7'h30 && c <= 7'h33) begin
        fr.push_back(byte'(c));
      end else if (fr.size() == 4 && c == 7'h2E) begin
        exp_pos = {fr[1][1:0], fr[2][1:0], fr[3][1:0]};
        n_at = 1;
        fr.delete();
      end else begin
        n_er = 1;
        fr.delete();
      end
    end else if (fr.size() > 0 && cyc - last == 49) begin
      n_er = 1;
      fr.delete();
    end
    exp_at = n_at;
    exp_er = n_er;
    exp_db = n_at ? 4'd5 : n_er ? 4'd6 : 4'(fr.size());
`ifdef RECEPTOR_ECO_EN
    exp_eco_p = n_at | n_er;
    if (n_at) exp_eco_d = 7'h4B;
    if (n_er) exp_eco_d = 7'h45;
`endif
    @(posedge clock); #1;
    cyc++;
  endtask

  task automatic send(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      repeat (gap - 1) step(1'b0, 7'h00);
      step(1'b1, 7'(s[i]));
    end
  endtask

  typedef struct {
    string      seq;
    logic [5:0] pos;
    int         n_at;
    int         n_er;
  } vec_t;
  vec_t tab[7];

  initial begin
    tab[0] = '{"#123.",     6'b011011, 1, 0};
    tab[1] = '{"#29",       6'b011011, 0, 1};
    tab[2] = '{"#3#001.",   6'b000001, 1, 0};
    tab[3] = '{"#333.",     6'b111111, 1, 0};
    tab[4] = '{"Z#012.",    6'b000110, 1, 0};
    tab[5] = '{"#01.",      6'b000110, 0, 1};
    tab[6] = '{"#123#321.", 6'b111001, 1, 0};
    do_reset();
    step(1'b0, 7'h00);
    for (int k = 0; k < 7; k++) begin
      na = 0;
      ne = 0;
      send(tab[k].seq, 20);
      repeat (3) step(1'b0, 7'h00);
      chk($sformatf("tab%0d_pos", k), {posicao1, posicao2, posicao3}, tab[k].pos);
      chk($sformatf("tab%0d_atualizado", k), na, tab[k].n_at);
      chk($sformatf("tab%0d_erro", k), ne, tab[k].n_er);
    end
    // Stalled frame: abort 50 cycles after the last character, then a clean frame.
    na = 0;
    ne = 0;
    send("#1", 20);
    repeat (60) step(1'b0, 7'h00);
    chk("timeout_erro", ne, 1);
    send("#333.", 20);
    repeat (3) step(1'b0, 7'h00);
    chk("timeout_pos", {posicao1, posicao2, posicao3}, 6'b111111);
    chk("timeout_atualizado", na, 1);
    // Reset in the middle of a frame discards it silently.
    na = 0;
    ne = 0;
    send("#12", 20);
    do_reset();
    send("3.", 20);
    repeat (3) step(1'b0, 7'h00);
    chk("reset_saidas", {posicao1, posicao2, posicao3, atualizado, erro, db_estado}, '0);
    chk("reset_pulsos", na + ne, 0);
    // Echo: one good frame then one bad one.
    ecos.delete();
    send("#123.", 20);
    send("#2x", 20);
    repeat (3) step(1'b0, 7'h00);
`ifdef RECEPTOR_ECO_EN
    chk("eco_qtd", ecos.size(), 2);
    if (ecos.size() == 2) begin
      chk("eco_k", ecos[0], 7'h4B);
      chk("eco_e", ecos[1], 7'h45);
    end
`else
    chk("eco_qtd", ecos.size(), 0);
`endif
    // Random frames, some corrupted, some stalled past the timeout.
    for (int f = 0; f < 80; f++) begin
      string s;
      s = "#";
      for (int d = 0; d < 3; d++) s = {s, string'(8'h30 + 8'($urandom_range(0, 3)))};
      s = {s, "."};
      if ($urandom_range(0, 3) == 0) s[$urandom_range(0, 4)] = 8'($urandom_range(32, 126));
      for (int i = 0; i < s.len(); i++) begin
        int g;
        g = ($urandom_range(0, 9) == 0) ? 70 : $urandom_range(2, 40);
        repeat (g - 1) step(1'b0, 7'($urandom));
        step(1'b1, 7'(s[i]));
      end
    end
    repeat (60) step(1'b0, 7'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
